// File: rtl/fetch_unit_if.sv
// Fetch-stage handshake bundle: execute redirect, decode stall/delivery, and the
// request/grant instruction-memory port. master = fetch unit, slave = its environment.
interface fetch_unit_if #(parameter int XLEN = 32);
  logic            PCSrcE;
  logic [XLEN-1:0] PCTargetE;
  logic            StallD;
  logic            ImemReq;
  logic [XLEN-1:0] ImemAddr;
  logic            ImemGnt;
  logic            ImemRValid;
  logic [31:0]     ImemRData;
  logic [31:0]     InstrD;
  logic [XLEN-1:0] PCD;
  logic [XLEN-1:0] PCPlus4D;
  logic            ValidD;

  modport master (
    input  PCSrcE, PCTargetE, StallD, ImemGnt, ImemRValid, ImemRData,
    output ImemReq, ImemAddr, InstrD, PCD, PCPlus4D, ValidD
  );
  modport slave (
    output PCSrcE, PCTargetE, StallD, ImemGnt, ImemRValid, ImemRData,
    input  ImemReq, ImemAddr, InstrD, PCD, PCPlus4D, ValidD
  );
endinterface

// File: rtl/fetch_unit.sv
// Decoupled fetch stage: credit-limited request/grant imem port feeding a QDEPTH prefetch
// queue; redirects flush the queue and discard in-flight responses. FETCH_PERF_CNT_EN adds counters.
module fetch_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h00000000,
  parameter int              QDEPTH       = 2
) (
  input  logic          clk,
  input  logic          rst,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]   FetchCnt,
  output logic [31:0]   SquashCnt,
`endif
  fetch_unit_if.master  bus
);
  localparam int CW  = $clog2(QDEPTH + 1);
  localparam int CW1 = CW + 1;
  localparam int PW  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  logic [XLEN-1:0] pcf_q, pcf_d, pcr_q, pcr_d;
  logic [CW-1:0]   out_q, out_d, disc_q, disc_d, cnt_q, cnt_d;
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic            valid_q, valid_d;
  logic [31:0]     instr_q [QDEPTH];
  logic [31:0]     instr_d [QDEPTH];
  logic [XLEN-1:0] qpc_q   [QDEPTH];
  logic [XLEN-1:0] qpc_d   [QDEPTH];
  logic [XLEN-1:0] qp4_q   [QDEPTH];
  logic [XLEN-1:0] qp4_d   [QDEPTH];

  logic pop_raw, pop, push, req, issue, drop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credit: in-flight plus queued may not exceed QDEPTH, counting this cycle's pop as freed.
  assign pop_raw = valid_q & ~bus.StallD;
  assign req     = rst & ~bus.PCSrcE &
                   (({1'b0, out_q} + {1'b0, cnt_q}) < (CW1'(QDEPTH) + CW1'(pop_raw)));
  assign issue   = req & bus.ImemGnt;
  assign pop     = pop_raw & ~bus.PCSrcE;
  assign drop    = bus.ImemRValid & (disc_q != '0);
  assign push    = bus.ImemRValid & (disc_q == '0) & ~bus.PCSrcE;

  always_comb begin
    pcf_d   = pcf_q;
    pcr_d   = pcr_q;
    out_d   = out_q + CW'(issue) - CW'(bus.ImemRValid);
    disc_d  = disc_q;
    cnt_d   = cnt_q;
    head_d  = head_q;
    tail_d  = tail_q;
    valid_d = valid_q;
    instr_d = instr_q;
    qpc_d   = qpc_q;
    qp4_d   = qp4_q;
    if (bus.PCSrcE) begin
      // Everything still in flight is younger than the redirect; a response landing now
      // is dropped along with the queue contents.
      pcf_d   = bus.PCTargetE;
      pcr_d   = bus.PCTargetE;
      disc_d  = out_q - CW'(bus.ImemRValid);
      cnt_d   = '0;
      head_d  = '0;
      tail_d  = '0;
      valid_d = 1'b0;
    end else begin
      if (issue) pcf_d = pcf_q + XLEN'(4);
      if (drop)  disc_d = disc_q - CW'(1);
      if (push) begin
        instr_d[tail_q] = bus.ImemRData;
        qpc_d[tail_q]   = pcr_q;
        qp4_d[tail_q]   = pcr_q + XLEN'(4);
        tail_d          = ptr_inc(tail_q);
        pcr_d           = pcr_q + XLEN'(4);
      end
      if (pop) head_d = ptr_inc(head_q);
      cnt_d   = cnt_q + CW'(push) - CW'(pop);
      valid_d = (cnt_d != '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcf_q   <= RESET_VECTOR;
      pcr_q   <= RESET_VECTOR;
      out_q   <= '0;
      disc_q  <= '0;
      cnt_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= 1'b0;
      for (int i = 0; i < QDEPTH; i++) begin
        instr_q[i] <= '0;
        qpc_q[i]   <= '0;
        qp4_q[i]   <= '0;
      end
    end else begin
      pcf_q   <= pcf_d;
      pcr_q   <= pcr_d;
      out_q   <= out_d;
      disc_q  <= disc_d;
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      qpc_q   <= qpc_d;
      qp4_q   <= qp4_d;
    end
  end

  assign bus.ImemReq  = req;
  assign bus.ImemAddr = pcf_q;
  assign bus.InstrD   = instr_q[head_q];
  assign bus.PCD      = qpc_q[head_q];
  assign bus.PCPlus4D = qp4_q[head_q];
  assign bus.ValidD   = valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d, squash_cnt_q, squash_cnt_d;

  always_comb begin
    fetch_cnt_d  = fetch_cnt_q + 32'(pop);
    squash_cnt_d = squash_cnt_q;
    if (bus.PCSrcE) squash_cnt_d = squash_cnt_q + 32'(cnt_q) + 32'(bus.ImemRValid);
    else if (drop)  squash_cnt_d = squash_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_q  <= '0;
      squash_cnt_q <= '0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end

  assign FetchCnt  = fetch_cnt_q;
  assign SquashCnt = squash_cnt_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: fixed-latency memory returning data = address,
// streaming, stall, redirect/discard, address wrap, async reset, optional counters.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   lat   = 1;

  fetch_unit_if #(.XLEN(32)) bus ();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt, squash_cnt;
`endif

  fetch_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .QDEPTH(2)) dut (
    .clk(clk),
    .rst(rst),
`ifdef FETCH_PERF_CNT_EN
    .FetchCnt(fetch_cnt),
    .SquashCnt(squash_cnt),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Memory: response for an issue in cycle N appears in cycle N+lat.
  logic [3:0]  pv;
  logic [31:0] pa [4];
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pv <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        pv[i] <= pv[i+1];
        pa[i] <= pa[i+1];
      end
      pv[3] <= 1'b0;
      if (bus.ImemReq && bus.ImemGnt) begin
        pv[lat-1] <= 1'b1;
        pa[lat-1] <= bus.ImemAddr;
      end
    end
  end
  assign bus.ImemRValid = pv[0];
  assign bus.ImemRData  = pa[0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc);
    chk({tag, ".valid"}, 32'(bus.ValidD), 32'd1);
    chk({tag, ".pcd"},   bus.PCD, pc);
    chk({tag, ".instr"}, bus.InstrD, pc);
    chk({tag, ".pcp4"},  bus.PCPlus4D, pc + 32'd4);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    bus.PCSrcE = 1'b0;
    bus.PCTargetE = '0;
    bus.StallD = 1'b0;
    bus.ImemGnt = 1'b1;
    #2;
    chk("rst.req",   32'(bus.ImemReq), 32'd0);
    chk("rst.valid", 32'(bus.ValidD), 32'd0);
    chk("rst.instr", bus.InstrD, 32'd0);
    chk("rst.pcd",   bus.PCD, 32'd0);
    chk("rst.pcp4",  bus.PCPlus4D, 32'd0);
    chk("rst.addr",  bus.ImemAddr, 32'd0);

    // Streaming, 1-cycle memory
    cyc(); rst = 1'b1; #1;
    chk("c0.req", 32'(bus.ImemReq), 32'd1);
    chk("c0.addr", bus.ImemAddr, 32'd0);
    chk("c0.valid", 32'(bus.ValidD), 32'd0);
    cyc(); #1;
    chk("c1.addr", bus.ImemAddr, 32'd4);
    chk("c1.valid", 32'(bus.ValidD), 32'd0);
    for (int k = 2; k <= 5; k++) begin
      cyc(); #1;
      chk_head("stream", 32'(4 * (k - 2)));
      chk("stream.addr", bus.ImemAddr, 32'(4 * k));
    end

    // Decode stall for 5 cycles
    cyc(); bus.StallD = 1'b1; #1;
    chk("stall0.pcd", bus.PCD, 32'd16);
    chk("stall0.req", 32'(bus.ImemReq), 32'd0);
    for (int k = 0; k < 4; k++) begin
      cyc(); #1;
      chk_head("stall.hold", 32'd16);
      chk("stall.req", 32'(bus.ImemReq), 32'd0);
    end
    cyc(); bus.StallD = 1'b0; #1;
    chk_head("rel", 32'd16);
    chk("rel.req", 32'(bus.ImemReq), 32'd1);
    chk("rel.addr", bus.ImemAddr, 32'd24);
    for (int k = 0; k < 3; k++) begin
      cyc(); #1;
      chk_head("after", 32'(20 + 4 * k));
      chk("after.addr", bus.ImemAddr, 32'(28 + 4 * k));
    end

    // Asynchronous reset mid-stream
    #3; rst = 1'b0; #1;
    chk("arst.valid", 32'(bus.ValidD), 32'd0);
    chk("arst.instr", bus.InstrD, 32'd0);
    chk("arst.pcd",   bus.PCD, 32'd0);
    chk("arst.pcp4",  bus.PCPlus4D, 32'd0);
    chk("arst.req",   32'(bus.ImemReq), 32'd0);

    // Redirect with two late responses, 3-cycle memory
    lat = 3;
    cyc(); cyc(); rst = 1'b1; #1;
    chk("r0.req", 32'(bus.ImemReq), 32'd1);
    chk("r0.addr", bus.ImemAddr, 32'd0);
    cyc(); #1;
    chk("r1.addr", bus.ImemAddr, 32'd4);
    cyc(); bus.PCSrcE = 1'b1; bus.PCTargetE = 32'h100; #1;
    chk("r2.req", 32'(bus.ImemReq), 32'd0);
    cyc(); bus.PCSrcE = 1'b0; #1;
    chk("r3.valid", 32'(bus.ValidD), 32'd0);
    chk("r3.req", 32'(bus.ImemReq), 32'd0);
    cyc(); #1;
    chk("r4.req", 32'(bus.ImemReq), 32'd1);
    chk("r4.addr", bus.ImemAddr, 32'h100);
    chk("r4.valid", 32'(bus.ValidD), 32'd0);
    for (int k = 5; k <= 7; k++) begin
      cyc(); #1;
      chk("r5_7.valid", 32'(bus.ValidD), 32'd0);
    end

    // Redirect coinciding with the only outstanding response
    cyc(); bus.PCSrcE = 1'b1; bus.PCTargetE = 32'h200; #1;
    chk_head("r8", 32'h100);
    chk("r8.req", 32'(bus.ImemReq), 32'd0);
    cyc(); bus.PCSrcE = 1'b0; #1;
    chk("r9.valid", 32'(bus.ValidD), 32'd0);
    chk("r9.req", 32'(bus.ImemReq), 32'd1);
    chk("r9.addr", bus.ImemAddr, 32'h200);
    for (int k = 10; k <= 12; k++) begin
      cyc(); #1;
      chk("r10_12.valid", 32'(bus.ValidD), 32'd0);
    end

    // Redirect to the top of the address space; PC arithmetic wraps
    cyc(); bus.PCSrcE = 1'b1; bus.PCTargetE = 32'hFFFF_FFFC; #1;
    chk_head("r13", 32'h200);
    cyc(); bus.PCSrcE = 1'b0; #1;
    chk("r14.addr", bus.ImemAddr, 32'hFFFF_FFFC);
    cyc(); #1;
    chk("r15.req", 32'(bus.ImemReq), 32'd1);
    chk("r15.addr", bus.ImemAddr, 32'd0);
    cyc(); cyc(); #1;
    chk("r17.valid", 32'(bus.ValidD), 32'd0);
    cyc(); #1;
    chk("r18.valid", 32'(bus.ValidD), 32'd1);
    chk("r18.pcd",   bus.PCD, 32'hFFFF_FFFC);
    chk("r18.pcp4",  bus.PCPlus4D, 32'd0);
    cyc(); #1;
    chk_head("r19", 32'd0);

`ifdef FETCH_PERF_CNT_EN
    // 10 pops, then redirect with one queued entry and one response landing
    #3; rst = 1'b0; lat = 1; #1;
    chk("perf.rst.fetch", fetch_cnt, 32'd0);
    chk("perf.rst.squash", squash_cnt, 32'd0);
    cyc(); rst = 1'b1;
    for (int k = 1; k <= 12; k++) cyc();
    bus.PCSrcE = 1'b1; bus.PCTargetE = 32'h300; #1;
    chk("perf.pcd", bus.PCD, 32'd40);
    cyc(); bus.PCSrcE = 1'b0; #1;
    chk("perf.fetch", fetch_cnt, 32'd10);
    chk("perf.squash", squash_cnt, 32'd2);
    chk("perf.valid", 32'(bus.ValidD), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised, decoupled instruction-fetch stage for the pipelined RISC-V core. It replaces the fixed single-register fetch-to-decode latch with a request/grant instruction-memory port and a QDEPTH-entry prefetch queue. A decode-stage stall holds the delivered instruction, and a taken branch/jump from execute redirects the PC and squashes every younger fetch, including responses still in flight. It sits between the instruction memory and the decode stage and drives InstrD/PCD/PCPlus4D plus a new ValidD qualifier.

## Interface
- XLEN, 32: width of PC, addresses and instruction word.
- RESET_VECTOR, 32'h00000000: PC fetched first after reset.
- QDEPTH, 2: prefetch queue entries; also the limit on in-flight plus queued fetches. Must be ≥1.
- clk  in  1  core clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- PCSrcE  in  1  redirect request from execute (taken branch/jump).
- PCTargetE  in  XLEN  redirect target.
- StallD  in  1  decode cannot accept; hold the current D outputs.
- ImemReq  out  1  fetch request valid.
- ImemAddr  out  XLEN  fetch address (PCF).
- ImemGnt  in  1  request accepted this cycle (ImemReq & ImemGnt = issue).
- ImemRValid  in  1  response valid; responses arrive in order, ≥1 cycle after their issue.
- ImemRData  in  32  instruction word.
- InstrD  out  32  queue head instruction.
- PCD  out  XLEN  queue head PC.
- PCPlus4D  out  XLEN  queue head PC+4.
- ValidD  out  1  queue head valid.

## Operation
- State: PCF (next issue address), PCR (PC of the next kept response), outstanding counter, discard counter, circular queue of {instr, pc, pc+4}, head/tail pointers and a count.
- Issue: ImemReq = rst & ~PCSrcE & (outstanding + count − pop < QDEPTH), with pop = ValidD & ~StallD. On issue, PCF += 4 and outstanding += 1. Outstanding decrements on each ImemRValid.
- Response: if discard > 0, the response is dropped and discard −= 1. Otherwise it is pushed as {ImemRData, PCR, PCR+4} and PCR += 4.
- Pop: when ValidD & ~StallD, head advances. Push and pop in the same cycle leave count unchanged.
- Redirect (PCSrcE=1): PCF ← PCTargetE and PCR ← PCTargetE. The queue is emptied (ValidD=0 next cycle). discard ← outstanding − (ImemRValid this cycle). No issue occurs in the redirect cycle, so there is never a same-cycle grant to account for. StallD is ignored.
- Queue can never overflow because of the credit rule. The pointers wrap modulo QDEPTH. Address arithmetic is modulo 2^XLEN, so 0xFFFFFFFC+4 wraps to 0.
- Reset (asynchronous, mid-operation allowed): PCF=PCR=RESET_VECTOR; counters, pointers and count are 0. All D outputs read 0, ValidD=0, ImemReq=0. Responses to requests issued before reset are not masked; the memory must be reset together with the core.

## Timing
- All outputs except ImemReq are registers. ImemReq depends combinationally on PCSrcE and StallD, with no path from ImemGnt.
- The first ImemReq, with ImemAddr=RESET_VECTOR, appears in the first cycle with rst high.
- Issue at cycle N with a 1-cycle memory gives ImemRValid at N+1 and ValidD/InstrD at N+2.
- With QDEPTH≥2 and a 1-cycle memory, throughput is one instruction per cycle sustained. With QDEPTH=1 it is one instruction every 2 cycles.
- Redirect asserted in cycle N gives ImemReq with ImemAddr=PCTargetE at N+1. With a 1-cycle memory, the first target instruction shows ValidD at N+3.

## Configuration
- FETCH_PERF_CNT_EN defined: adds outputs FetchCnt (out, 32), the count of instructions popped to decode, and SquashCnt (out, 32), the count of queue entries flushed plus responses discarded. Both reset to 0 and wrap at 2^32.
- Undefined: the ports and counters are absent, and all other behaviour is identical.

## Test plan
- Reset, then ImemGnt=1 and a 1-cycle memory returning data=address → ImemAddr 0,4,8… issued every cycle. ValidD rises 2 cycles after the first issue, then PCD=0,4,8 with InstrD=PCD and PCPlus4D=PCD+4, one per cycle.
- StallD=1 for 5 cycles mid-stream (QDEPTH=2) → InstrD/PCD hold. ImemReq drops once outstanding+count=2. After release, the sequence continues with no gap or duplicate.
- Memory latency 3, two requests outstanding, PCSrcE=1 with PCTargetE=0x100 → both late responses are dropped. ValidD=0 until the 0x100 instruction arrives, and PCD=0x100 first.
- Redirect in the same cycle as ImemRValid with outstanding=1 → discard=0, that response is dropped with the queue, and the target fetch is kept.
- Assert rst low mid-stream → asynchronously ValidD=0, InstrD/PCD/PCPlus4D=0, ImemReq=0. On release, the fetch restarts at RESET_VECTOR.
- With FETCH_PERF_CNT_EN: fetch 10, redirect with 1 queued and 1 in flight → FetchCnt=10, SquashCnt=2.
